// File: rtl/cipher_pkg.sv
// Shared types and constants for the cipher demultiplexer.
package cipher_pkg;

    localparam int unsigned D_WIDTH_DEF     = 8;
    localparam logic [7:0]  START_TOKEN_DEF = 8'hFA;

    // Engine indices as presented on select / busy_i
    localparam logic [1:0] CAESAR      = 2'd0;
    localparam logic [1:0] SCYTALE     = 2'd1;
    localparam logic [1:0] ZIGZAG      = 2'd2;
    localparam logic [1:0] SEL_INVALID = 2'd3;

    typedef enum logic [1:0] {
        StIdle,
        StForward,
        StWaitRise,
        StWaitFall
    } state_e;

    // One-hot strobe for an engine index; the invalid index maps to no strobe.
    function automatic logic [2:0] engine_onehot(input logic [1:0] sel);
        logic [2:0] oh;
        oh = 3'b000;
        case (sel)
            CAESAR:  oh = 3'b001;
            SCYTALE: oh = 3'b010;
            ZIGZAG:  oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; rdata_o always presents the head entry.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Storage array, written on an accepted push.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers and occupancy; push and pop together leave count unchanged.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/cipher_demux.sv
// Buffers encrypted characters and forwards each message to one decryption
// engine, then waits for that engine's busy handshake before the next message.
// Optional message statistics: define CIPHER_DEMUX_STATS_EN.
module cipher_demux
    import cipher_pkg::*;
#(
    parameter int unsigned         D_WIDTH                = D_WIDTH_DEF,
    parameter int unsigned         MAX_NOF_CHARS          = 50,
    parameter logic [D_WIDTH-1:0]  START_DECRYPTION_TOKEN = D_WIDTH'(START_TOKEN_DEF),
    parameter int unsigned         FIFO_DEPTH             = 4,
    parameter int unsigned         RISE_TIMEOUT           = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [D_WIDTH-1:0] data_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [1:0]         select,
    input  logic [2:0]         busy_i,
    output logic [D_WIDTH-1:0] data_o,
    output logic [2:0]         valid_o,
    output logic               error_o,
    output logic [15:0]        msg_count_o
);

    localparam int unsigned FCW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned CCW = $clog2(MAX_NOF_CHARS + 1);
    localparam int unsigned RCW = $clog2(RISE_TIMEOUT + 1);

    state_e             state_q;
    logic [1:0]         sel_q;
    logic [CCW-1:0]     char_cnt_q;
    logic [RCW-1:0]     rise_cnt_q;

    logic               fifo_full;
    logic               fifo_empty;
    logic [FCW-1:0]     fifo_count;
    logic [D_WIDTH-1:0] head;
    logic               pop;
    logic [1:0]         cur_sel;
    logic [CCW-1:0]     cur_cnt;
    logic               is_tok;
    logic [3:0]         busy_ext;
    logic               busy_sel;

    assign ready_o = !fifo_full;

    sync_fifo #(
        .WIDTH (D_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (valid_i && ready_o),
        .wdata_i (data_i),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Full flag must agree with the occupancy count that ready_o relies on.
    full_matches_count: assert property (@(posedge clk) disable iff (!rst_n)
        fifo_full == (fifo_count == FCW'(FIFO_DEPTH)));

    // Pop decision and per-pop context; in IDLE the message is just starting.
    always_comb begin
        pop      = !fifo_empty && (state_q == StIdle || state_q == StForward);
        cur_sel  = (state_q == StIdle) ? select : sel_q;
        cur_cnt  = (state_q == StIdle) ? '0 : char_cnt_q;
        is_tok   = (head == START_DECRYPTION_TOKEN);
        busy_ext = {1'b0, busy_i};
        busy_sel = busy_ext[sel_q];
    end

    // Message FSM with registered forwarding outputs and sticky error.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            sel_q      <= '0;
            char_cnt_q <= '0;
            rise_cnt_q <= '0;
            data_o     <= '0;
            valid_o    <= '0;
            error_o    <= 1'b0;
        end else begin
            valid_o <= '0;
            unique case (state_q)
                StIdle, StForward: begin
                    if (pop) begin
                        sel_q <= cur_sel;
                        if (cur_sel == SEL_INVALID) begin
                            // Drain the message silently; token ends it without handshake.
                            error_o <= 1'b1;
                            state_q <= is_tok ? StIdle : StForward;
                        end else if (is_tok) begin
                            data_o     <= head;
                            valid_o    <= engine_onehot(cur_sel);
                            rise_cnt_q <= '0;
                            state_q    <= StWaitRise;
                        end else if (cur_cnt >= CCW'(MAX_NOF_CHARS)) begin
                            error_o    <= 1'b1;
                            char_cnt_q <= cur_cnt;
                            state_q    <= StForward;
                        end else begin
                            data_o     <= head;
                            valid_o    <= engine_onehot(cur_sel);
                            char_cnt_q <= cur_cnt + CCW'(1);
                            state_q    <= StForward;
                        end
                    end
                end
                StWaitRise: begin
                    if (busy_sel) begin
                        state_q <= StWaitFall;
                    end else if (rise_cnt_q == RCW'(RISE_TIMEOUT - 1)) begin
                        error_o <= 1'b1;
                        state_q <= StIdle;
                    end else begin
                        rise_cnt_q <= rise_cnt_q + RCW'(1);
                    end
                end
                StWaitFall: begin
                    if (!busy_sel) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef CIPHER_DEMUX_STATS_EN
    logic [15:0] msg_cnt_q;
    logic        tok_fwd;

    assign tok_fwd = pop && is_tok && (cur_sel != SEL_INVALID);

    // Count messages whose token reaches a valid engine; wraps at 16 bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            msg_cnt_q <= '0;
        end else if (tok_fwd) begin
            msg_cnt_q <= msg_cnt_q + 16'd1;
        end
    end

    assign msg_count_o = msg_cnt_q;
`else
    assign msg_count_o = '0;
`endif

endmodule

// File: tb/tb_cipher_demux.sv
// Scoreboard bench for cipher_demux: expected outputs are queued on accept.
module tb_cipher_demux;
    import cipher_pkg::*;

    localparam logic [7:0] TOK = 8'hFA;
    localparam int         MAXC = 50;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  data_i = '0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [1:0]  select = 2'd0;
    logic [2:0]  busy_i = '0;
    logic [7:0]  data_o;
    logic [2:0]  valid_o;
    logic        error_o;
    logic [15:0] msg_count_o;

    typedef struct {
        logic [2:0] sel;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   vld_cnt = 0;
    int   run = 0;
    int   max_run = 0;
    int   acc_cyc = 0;
    // Message model state
    logic       m_first = 1'b1;
    logic [1:0] m_sel = 2'd0;
    int         m_cnt = 0;
    logic       exp_err = 1'b0;
    int         exp_msgs = 0;

    cipher_demux dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .data_i      (data_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .select      (select),
        .busy_i      (busy_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .error_o     (error_o),
        .msg_count_o (msg_count_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Output monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (valid_o != 3'b000) begin
            exp_t e;
            vld_cnt++;
            run++;
            if (run > max_run) max_run = run;
            if (sb.size() == 0) begin
                check_eq("unexpected_valid", {29'd0, valid_o}, 32'd0);
            end else begin
                e = sb.pop_front();
                check_eq("valid_sel", {29'd0, valid_o}, {29'd0, e.sel});
                check_eq("data", {24'd0, data_o}, {24'd0, e.data});
            end
        end else begin
            run = 0;
        end
    end

    // Reference behaviour for an accepted character.
    task automatic model_accept(input logic [7:0] c);
        if (m_first) begin
            m_sel   = select;
            m_cnt   = 0;
            m_first = 1'b0;
        end
        if (m_sel == 2'd3) begin
            exp_err = 1'b1;
            if (c == TOK) m_first = 1'b1;
        end else if (c == TOK) begin
            sb.push_back('{sel: 3'(1 << m_sel), data: c});
            m_first = 1'b1;
            exp_msgs++;
        end else if (m_cnt < MAXC) begin
            sb.push_back('{sel: 3'(1 << m_sel), data: c});
            m_cnt++;
        end else begin
            exp_err = 1'b1;
        end
    endtask

    // Entered and left at posedge+1; holds valid_i until accepted.
    task automatic push_char(input logic [7:0] c);
        int   n;
        logic acc;
        n       = 0;
        acc     = 1'b0;
        data_i  = c;
        valid_i = 1'b1;
        while (!acc && n < 200) begin
            acc = ready_o;
            @(posedge clk);
            #1;
            n++;
        end
        valid_i = 1'b0;
        if (!acc) check_eq("push_timeout", 32'd0, 32'd1);
        else begin
            acc_cyc = cyc;
            model_accept(c);
        end
    endtask

    // Returns at the negedge where the token is on the output.
    task automatic wait_tok();
        int n;
        n = 0;
        while (!(valid_o != 3'b000 && data_o == TOK) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) check_eq("token_timeout", 32'd0, 32'd1);
    endtask

    task automatic ack(input int sel, input int hold);
        wait_tok();
        @(posedge clk);
        #1;
        busy_i[sel] = 1'b1;
        repeat (hold) @(posedge clk);
        #1;
        busy_i = '0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        valid_i = 1'b0;
        busy_i  = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_ready", {31'd0, ready_o}, 32'd1);
        check_eq("rst_valid", {29'd0, valid_o}, 32'd0);
        check_eq("rst_data", {24'd0, data_o}, 32'd0);
        check_eq("rst_error", {31'd0, error_o}, 32'd0);
        check_eq("rst_msgcnt", {16'd0, msg_count_o}, 32'd0);
        check_eq("rst_state", {30'd0, dut.state_q}, {30'd0, StIdle});
        rst_n = 1'b1;
        sb.delete();
        m_first  = 1'b1;
        exp_err  = 1'b0;
        exp_msgs = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0;
        int n;
        int fall_cyc;
        int acc5;
        logic [7:0] bp_chars [6];
        bp_chars = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36};
        fall_cyc = 0;
        acc5     = 0;

        @(posedge clk);
        #1;
        do_reset();

        // Single message to zigzag
        select  = 2'd2;
        max_run = 0;
        push_char("H");
        push_char("I");
        push_char(TOK);
        ack(2, 5);
        check_eq("s1_run", max_run, 3);
        check_eq("s1_idle", {30'd0, dut.state_q}, {30'd0, StIdle});
        check_eq("s1_error", {31'd0, error_o}, {31'd0, exp_err});
        check_eq("s1_drain", sb.size(), 0);

        // Backpressure while the engine stays busy
        push_char("P");
        push_char(TOK);
        wait_tok();
        @(posedge clk);
        #1;
        busy_i = 3'b100;
        fork
            begin
                repeat (20) @(posedge clk);
                #1;
                busy_i   = '0;
                fall_cyc = cyc;
            end
            begin
                for (int i = 0; i < 6; i++) begin
                    push_char(bp_chars[i]);
                    if (i == 3) check_eq("bp_ready_low", {31'd0, ready_o}, 32'd0);
                    if (i == 4) acc5 = acc_cyc;
                end
            end
        join
        check_eq("bp_after_fall", {31'd0, acc5 > fall_cyc}, 32'd1);
        push_char(TOK);
        ack(2, 3);
        check_eq("bp_drain", sb.size(), 0);
        check_eq("bp_ready", {31'd0, ready_o}, 32'd1);
        check_eq("bp_error", {31'd0, error_o}, {31'd0, exp_err});

        // Engine never answers
        do_reset();
        select = 2'd1;
        push_char("T");
        push_char(TOK);
        wait_tok();
        check_eq("to_err_early", {31'd0, error_o}, 32'd0);
        n = 0;
        while (dut.state_q != StIdle && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("to_cycles", n, 4);
        check_eq("to_error", {31'd0, error_o}, 32'd1);
        @(posedge clk);
        #1;
        check_eq("to_drain", sb.size(), 0);

        // Invalid engine select
        do_reset();
        select = 2'd3;
        v0     = vld_cnt;
        push_char("A");
        push_char(TOK);
        repeat (8) @(posedge clk);
        #1;
        check_eq("inv_no_valid", vld_cnt - v0, 0);
        check_eq("inv_error", {31'd0, error_o}, {31'd0, exp_err});
        check_eq("inv_idle", {30'd0, dut.state_q}, {30'd0, StIdle});

        // Overlength message
        do_reset();
        select = 2'd0;
        v0     = vld_cnt;
        for (int i = 0; i < 52; i++) push_char(8'(8'h30 + i));
        push_char(TOK);
        ack(0, 2);
        check_eq("ovl_count", vld_cnt - v0, MAXC + 1);
        check_eq("ovl_error", {31'd0, error_o}, {31'd0, exp_err});
        check_eq("ovl_drain", sb.size(), 0);

        // Reset in the middle of buffered traffic
        do_reset();
        select = 2'd0;
        push_char("M");
        push_char(TOK);
        wait_tok();
        @(posedge clk);
        #1;
        busy_i = 3'b001;
        push_char("N");
        push_char("O");
        do_reset();
        v0 = vld_cnt;
        repeat (10) @(posedge clk);
        #1;
        check_eq("mid_rst_no_valid", vld_cnt - v0, 0);

        // Two complete messages for statistics
        select = 2'd1;
        push_char("S");
        push_char(TOK);
        ack(1, 2);
        push_char("U");
        push_char(TOK);
        ack(1, 2);
        check_eq("st_drain", sb.size(), 0);
`ifdef CIPHER_DEMUX_STATS_EN
        check_eq("st_msgcnt", {16'd0, msg_count_o}, exp_msgs);
`else
        check_eq("st_msgcnt", {16'd0, msg_count_o}, 32'd0);
`endif
        check_eq("st_error", {31'd0, error_o}, {31'd0, exp_err});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
